// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one 1R1W no-change block RAM among NUM_REQ requesters.
// Define BRAM_ARB_LOCK_EN to let a requester hold its grant across beats (atomic read-modify-write).
module bram_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_COL    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ-1:0]            req_lock,
   input  logic [NUM_REQ*NUM_COL-1:0]    req_be,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [NUM_COL-1:0]            bram_wr_en,
   output logic [ADDR_WIDTH-1:0]         bram_wr_addr,
   output logic [DATA_WIDTH-1:0]         bram_wr_data,
   output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
   input  logic [DATA_WIDTH-1:0]         bram_rd_data
);

   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [LW-1:0]         last_q, last_d;
   logic [NUM_COL-1:0]    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [LW-1:0]         tag_q, tag_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;

   logic [NUM_REQ-1:0]    eligible_s;
   logic                  accept_s;
   logic [LW-1:0]         grant_idx_s;
   logic                  grant_write_s;
   logic [NUM_COL-1:0]    grant_be_s;
   logic [ADDR_WIDTH-1:0] grant_addr_s;
   logic [DATA_WIDTH-1:0] grant_wdata_s;

`ifdef BRAM_ARB_LOCK_EN
   logic                  lock_active_q, lock_active_d;
   logic [LW-1:0]         lock_owner_q, lock_owner_d;
   logic                  grant_lock_s;
`else
   logic                  unused_lock_s;
   assign unused_lock_s = ^req_lock;
`endif

   function automatic int rr_idx(input logic [LW-1:0] base, input int step);
      return (int'(base) + step) % NUM_REQ;
   endfunction

   // While locked only the owner may be granted; nothing is granted during reset.
   always_comb begin
`ifdef BRAM_ARB_LOCK_EN
      eligible_s = lock_active_q ? (req_valid & (ONE << lock_owner_q)) : req_valid;
`else
      eligible_s = req_valid;
`endif
      eligible_s = reset ? '0 : eligible_s;
   end

   // Walk from lowest to highest priority so the highest-priority valid requester wins.
   always_comb begin
      accept_s    = 1'b0;
      grant_idx_s = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         accept_s    = eligible_s[rr_idx(last_q, k)] ? 1'b1 : accept_s;
         grant_idx_s = eligible_s[rr_idx(last_q, k)] ? LW'(rr_idx(last_q, k)) : grant_idx_s;
      end
   end

   assign req_ready = accept_s ? (ONE << grant_idx_s) : '0;

   // Select the granted requester's command fields.
   always_comb begin
      grant_write_s = 1'b0;
      grant_be_s    = '0;
      grant_addr_s  = '0;
      grant_wdata_s = '0;
`ifdef BRAM_ARB_LOCK_EN
      grant_lock_s  = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_write_s = (grant_idx_s == LW'(i)) ? req_write[i] : grant_write_s;
         grant_be_s    = (grant_idx_s == LW'(i)) ? req_be[i*NUM_COL +: NUM_COL] : grant_be_s;
         grant_addr_s  = (grant_idx_s == LW'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : grant_addr_s;
         grant_wdata_s = (grant_idx_s == LW'(i)) ? req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : grant_wdata_s;
`ifdef BRAM_ARB_LOCK_EN
         grant_lock_s  = (grant_idx_s == LW'(i)) ? req_lock[i] : grant_lock_s;
`endif
      end
   end

   // Next-state for the command stage, pointer, lock and response pipeline.
   always_comb begin
      last_d       = last_q;
      wr_en_d      = '0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      rd_addr_d    = rd_addr_q;
      tag_d        = tag_q;
      rd_pending_d = 1'b0;
`ifdef BRAM_ARB_LOCK_EN
      lock_active_d = lock_active_q;
      lock_owner_d  = lock_owner_q;
`endif
      if (accept_s) begin
         last_d = grant_idx_s;
`ifdef BRAM_ARB_LOCK_EN
         lock_active_d = grant_lock_s;
         lock_owner_d  = grant_idx_s;
`endif
         if (grant_write_s) begin
            wr_en_d   = grant_be_s;
            wr_addr_d = grant_addr_s;
            wr_data_d = grant_wdata_s;
         end else begin
            rd_addr_d    = grant_addr_s;
            tag_d        = grant_idx_s;
            rd_pending_d = 1'b1;
         end
      end else begin
         last_d = last_q;
      end
      rsp_valid_d = rd_pending_q ? (ONE << tag_q) : '0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q       <= LW'(NUM_REQ - 1);
         wr_en_q      <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         rd_addr_q    <= '0;
         tag_q        <= '0;
         rd_pending_q <= 1'b0;
         rsp_valid_q  <= '0;
`ifdef BRAM_ARB_LOCK_EN
         lock_active_q <= 1'b0;
         lock_owner_q  <= '0;
`endif
      end else begin
         last_q       <= last_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         rd_addr_q    <= rd_addr_d;
         tag_q        <= tag_d;
         rd_pending_q <= rd_pending_d;
         rsp_valid_q  <= rsp_valid_d;
`ifdef BRAM_ARB_LOCK_EN
         lock_active_q <= lock_active_d;
         lock_owner_q  <= lock_owner_d;
`endif
      end
   end

   // Outputs are forced low for the whole time reset is held, including its first cycle.
   assign bram_wr_en   = reset ? '0 : wr_en_q;
   assign bram_wr_addr = reset ? '0 : wr_addr_q;
   assign bram_wr_data = reset ? '0 : wr_data_q;
   assign bram_rd_addr = reset ? '0 : rd_addr_q;
   assign rsp_valid    = reset ? '0 : rsp_valid_q;
   assign rsp_data     = reset ? '0 : bram_rd_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: scenario tasks with inline checks, plus a response scoreboard fed by
// a reference arbitration/memory model and drained against rsp_valid/rsp_data.
`timescale 1ns/1ps
module tb_bram_arbiter;
   localparam int NR = 3;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int NC = 2;
   localparam int CW = DW / NC;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid;
   logic [NR*NC-1:0] req_be;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]    rsp_data, bram_wr_data, bram_rd_data;
   logic [NC-1:0]    bram_wr_en;
   logic [AW-1:0]    bram_wr_addr, bram_rd_addr;

   typedef struct {
      int            due;
      int            req;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          sb_q[$];
   logic [DW-1:0] shadow [16];
   logic [DW-1:0] mem [16];
   int            ref_last, ref_owner;
   bit            ref_lock;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   bram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COL(NC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_lock(req_lock), .req_be(req_be), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
      .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // 1R1W RAM with column enables in no-change mode: a write cycle leaves rd_data untouched.
   always @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < 16; a++) mem[a] <= '0;
         bram_rd_data <= '0;
      end else if (|bram_wr_en) begin
         for (int c = 0; c < NC; c++)
            if (bram_wr_en[c]) mem[bram_wr_addr][c*CW +: CW] <= bram_wr_data[c*CW +: CW];
      end else begin
         bram_rd_data <= mem[bram_rd_addr];
      end
   end

   task automatic idle_all();
      req_valid = '0; req_write = '0; req_lock = '0;
      req_be = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int i, input bit wr, input bit lk, input logic [NC-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_lock[i]  = lk;
      req_be[i*NC +: NC]    = be;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // Scoreboard: pop the response due this cycle and compare, or require silence.
   task automatic sb_check();
      logic [NR-1:0] exp_v;
      if (!reset) begin
         checks++;
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_v = '0;
            exp_v[sb_q[0].req] = 1'b1;
            if (rsp_valid !== exp_v || rsp_data !== sb_q[0].data) begin
               errors++;
               $display("FAIL sb_rsp: cycle %0d got valid=%b data=%h, expected valid=%b data=%h",
                        cyc, rsp_valid, rsp_data, exp_v, sb_q[0].data);
            end
            void'(sb_q.pop_front());
         end else if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL sb_idle: cycle %0d got rsp_valid=%b, expected 0", cyc, rsp_valid);
         end
      end
   endtask

   // Reference arbiter and memory: predicts this cycle's grant and pushes expected read data.
   task automatic model_step(output logic [NR-1:0] exp_g);
      int            idx;
      bit            elig;
      logic [AW-1:0] a;
      exp_g = '0;
      if (reset) begin
         sb_q.delete();
         ref_last = NR - 1; ref_lock = 1'b0; ref_owner = 0;
         for (int k = 0; k < 16; k++) shadow[k] = '0;
         return;
      end
      for (int k = 1; k <= NR; k++) begin
         idx  = (ref_last + k) % NR;
         elig = req_valid[idx];
`ifdef BRAM_ARB_LOCK_EN
         if (ref_lock && idx != ref_owner) elig = 1'b0;
`endif
         if (elig) begin
            exp_g[idx] = 1'b1;
            ref_last   = idx;
`ifdef BRAM_ARB_LOCK_EN
            ref_lock  = req_lock[idx];
            ref_owner = idx;
`endif
            a = req_addr[idx*AW +: AW];
            if (req_write[idx]) begin
               for (int c = 0; c < NC; c++)
                  if (req_be[idx*NC + c]) shadow[a][c*CW +: CW] = req_wdata[idx*DW + c*CW +: CW];
            end else begin
               sb_q.push_back('{due: cyc + 2, req: idx, data: shadow[a]});
            end
            break;
         end
      end
   endtask

   task automatic sample(output logic [NR-1:0] g);
      @(negedge clk);
      sb_check();
      model_step(g);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      logic [NR-1:0] g;
      reset = 1'b1;
      idle_all();
      sample(g);
      advance();
      reset = 1'b0;
   endtask

   task automatic drain(input int n);
      logic [NR-1:0] g;
      idle_all();
      repeat (n) begin
         sample(g);
         advance();
      end
   endtask

   task automatic test_reset();
      logic [NR-1:0] g;
      reset = 1'b1;
      idle_all();
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, 2'b11, 4'(r + 1), 16'hBEEF);
      repeat (2) begin
         sample(g);
         checks++;
         if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || bram_wr_en !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b rsp_valid=%b wr_en=%b, expected all 0", req_ready, rsp_valid, bram_wr_en);
         end
         checks++;
         if (bram_wr_addr !== 4'h0 || bram_rd_addr !== 4'h0 || bram_wr_data !== 16'h0000 || rsp_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: wr_addr=%h rd_addr=%h wr_data=%h rsp_data=%h, expected all 0",
                     bram_wr_addr, bram_rd_addr, bram_wr_data, rsp_data);
         end
         advance();
      end
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      logic [NR-1:0] g;
      idle_all();
      set_req(0, 1'b1, 1'b0, 2'b11, 4'd3, 16'h00A5);
      sample(g);
      checks++;
      if (req_ready !== g || req_ready !== 3'b001) begin
         errors++;
         $display("FAIL wr_grant: got %b expected %b", req_ready, 3'b001);
      end
      advance();
      idle_all();
      set_req(0, 1'b0, 1'b0, 2'b00, 4'd3, 16'h0000);
      sample(g);
      checks++;
      if (bram_wr_en !== 2'b11 || bram_wr_addr !== 4'd3 || bram_wr_data !== 16'h00A5 || req_ready !== g) begin
         errors++;
         $display("FAIL wr_port: wr_en=%b addr=%h data=%h ready=%b, expected 11/3/00a5/%b",
                  bram_wr_en, bram_wr_addr, bram_wr_data, req_ready, g);
      end
      advance();
      idle_all();
      sample(g);
      checks++;
      if (bram_wr_en !== 2'b00 || bram_rd_addr !== 4'd3) begin
         errors++;
         $display("FAIL rd_port: wr_en=%b rd_addr=%h, expected 00/3", bram_wr_en, bram_rd_addr);
      end
      advance();
      sample(g);
      checks++;
      if (rsp_valid !== 3'b001 || rsp_data !== 16'h00A5) begin
         errors++;
         $display("FAIL rd_after_wr: valid=%b data=%h, expected 001/00a5", rsp_valid, rsp_data);
      end
      advance();
      drain(2);
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] g, exp_c;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         idle_all();
         for (int r = 0; r < NR; r++) begin
            if (i < 3) set_req(r, 1'b1, 1'b0, 2'b11, 4'(8 + r), 16'hC0A0 + 16'(r));
            else       set_req(r, 1'b0, 1'b0, 2'b00, 4'(8 + r), 16'h0000);
         end
         sample(g);
         exp_c = '0;
         exp_c[i % 3] = 1'b1;
         checks++;
         if (req_ready !== g || req_ready !== exp_c) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_c);
         end
         advance();
      end
      drain(3);
   endtask

   task automatic test_byte_enable();
      logic [NR-1:0] g;
      for (int s = 0; s < 3; s++) begin
         idle_all();
         if (s == 0)      set_req(1, 1'b1, 1'b0, 2'b11, 4'd5, 16'hFFFF);
         else if (s == 1) set_req(1, 1'b1, 1'b0, 2'b01, 4'd5, 16'h1234);
         else             set_req(1, 1'b0, 1'b0, 2'b00, 4'd5, 16'h0000);
         sample(g);
         checks++;
         if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL be_grant[%0d]: got %b expected 010", s, req_ready);
         end
         advance();
      end
      idle_all();
      sample(g);
      advance();
      sample(g);
      checks++;
      if (rsp_valid !== 3'b010 || rsp_data !== 16'hFF34) begin
         errors++;
         $display("FAIL be_merge: valid=%b data=%h, expected 010/ff34", rsp_valid, rsp_data);
      end
      advance();
      drain(1);
   endtask

   task automatic test_zero_be();
      logic [NR-1:0] g;
      idle_all();
      set_req(2, 1'b1, 1'b0, 2'b11, 4'd7, 16'h0011);
      sample(g);
      advance();
      idle_all();
      set_req(2, 1'b1, 1'b0, 2'b00, 4'd7, 16'h00EE);
      sample(g);
      checks++;
      if (req_ready !== 3'b100) begin
         errors++;
         $display("FAIL zbe_accept: got %b expected 100", req_ready);
      end
      advance();
      idle_all();
      set_req(2, 1'b0, 1'b0, 2'b00, 4'd7, 16'h0000);
      sample(g);
      checks++;
      if (bram_wr_en !== 2'b00) begin
         errors++;
         $display("FAIL zbe_wr_en: got %b expected 00", bram_wr_en);
      end
      advance();
      idle_all();
      sample(g);
      advance();
      sample(g);
      checks++;
      if (rsp_valid !== 3'b100 || rsp_data !== 16'h0011) begin
         errors++;
         $display("FAIL zbe_data: valid=%b data=%h, expected 100/0011", rsp_valid, rsp_data);
      end
      advance();
      drain(1);
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] g;
      idle_all();
      set_req(1, 1'b0, 1'b0, 2'b00, 4'd8, 16'h0000);
      sample(g);
      advance();
      reset = 1'b1;
      idle_all();
      sample(g);
      checks++;
      if (req_ready !== 3'b000 || rsp_valid !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset: ready=%b rsp_valid=%b, expected 000/000", req_ready, rsp_valid);
      end
      advance();
      reset = 1'b0;
      for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, 2'b00, 4'(r), 16'h0000);
      sample(g);
      checks++;
      if (req_ready !== g || req_ready !== 3'b001 || rsp_valid !== 3'b000) begin
         errors++;
         $display("FAIL post_reset: ready=%b rsp_valid=%b, expected 001/000", req_ready, rsp_valid);
      end
      advance();
      drain(3);
   endtask

   task automatic test_lock();
      logic [NR-1:0] g, exp_c;
      for (int s = 0; s < 6; s++) begin
         idle_all();
         set_req(0, 1'b0, 1'b0, 2'b00, 4'd1, 16'h0000);
         if (s == 1) set_req(1, 1'b0, 1'b1, 2'b00, 4'd2, 16'h0000);
         if (s == 4) set_req(1, 1'b1, 1'b0, 2'b11, 4'd2, 16'h5A5A);
         if (s == 1 || s == 4) exp_c = 3'b010;
`ifdef BRAM_ARB_LOCK_EN
         else if (s == 2 || s == 3) exp_c = 3'b000;
`endif
         else exp_c = 3'b001;
         sample(g);
         checks++;
         if (req_ready !== g || req_ready !== exp_c) begin
            errors++;
            $display("FAIL lock_grant[%0d]: got %b expected %b", s, req_ready, exp_c);
         end
         advance();
      end
      drain(3);
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      advance();
      test_reset();
      test_write_read();
      test_round_robin();
      test_byte_enable();
      test_zero_be();
      test_reset_mid();
      test_lock();
      checks++;
      if (sb_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_empty: %0d responses outstanding, expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Round-robin arbiter that shares one 1R1W block RAM (column write enables, no-change read mode) among NUM_REQ requesters. It accepts one read or one write per cycle, registers the selected command onto the RAM ports, and returns read data to the issuing requester two cycles after acceptance. It sits between the RAM and its clients, such as a cache tag/data array shared by a fetch unit and a fill unit. Because it never issues a read and a write to the RAM in the same cycle, no read is ever dropped by no-change mode.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- ADDR_WIDTH, 4: RAM address width
- DATA_WIDTH, 8: RAM data width
- NUM_COL, 1: write-enable columns; DATA_WIDTH divisible by NUM_COL
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle; at most one bit set
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold grant after this beat (see Configuration)
- req_be  in  NUM_REQ*NUM_COL  column write mask, requester i at [i*NUM_COL +: NUM_COL]
- req_addr  in  NUM_REQ*ADDR_WIDTH  address, packed the same way
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data, packed the same way
- rsp_valid  out  NUM_REQ  one-hot; read data valid for that requester
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- bram_wr_en  out  NUM_COL  to RAM wr_en
- bram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr
- bram_wr_data  out  DATA_WIDTH  to RAM wr_data
- bram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr
- bram_rd_data  in  DATA_WIDTH  from RAM rd_data

## Operation
- Arbitration is combinational from req_valid, the round-robin pointer `last` and the lock state.
  - Priority order is last+1, last+2, … wrapping modulo NUM_REQ.
  - req_ready[i] = 1 for the first valid requester in that order.
  - Acceptance = req_valid[i] & req_ready[i]. On acceptance, `last` <= i.
- Stage C (registered command), loaded in the cycle after acceptance:
  - Write: bram_wr_en = req_be, bram_wr_addr = req_addr, bram_wr_data = req_wdata. bram_rd_addr holds its previous value.
  - Read: bram_wr_en = 0, bram_rd_addr = req_addr. Tag register = requester index, rd_pending = 1.
  - No acceptance: bram_wr_en = 0; all other stage C fields hold.
- A write with req_be = 0 is accepted and uses its slot. It has no RAM effect and produces no response.
- Response: rsp_valid[tag] = rd_pending delayed one cycle. rsp_data = bram_rd_data, passed through combinationally.
- Writes produce no response. The response path has no backpressure; requesters must always sink rsp_valid.
- Reads and writes from different requesters complete in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Reset clears `last` to NUM_REQ-1 (so requester 0 has first priority), releases any lock, and zeroes bram_wr_en, rd_pending, rsp_valid and all address/data registers.
- Reset mid-operation: a read in flight is discarded and no rsp_valid is produced.

## Timing
- Request accepted in cycle N:
  - RAM port driven in N+1.
  - Write committed at the end of N+1.
  - Read response: rsp_valid and rsp_data in N+2.
- Throughput: one request per cycle, any read/write mix.
- req_ready depends combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- While reset is high: req_ready = 0 and every output is 0.

## Configuration
- BRAM_ARB_LOCK_EN defined:
  - Accepting a beat with req_lock[i] = 1 sets lock owner = i. Only i can be granted until i is accepted with req_lock[i] = 0; that beat is granted and releases the lock.
  - Idle cycles from the owner keep the lock; other requesters stay blocked.
  - `last` updates normally on each accepted beat. Used for atomic read-modify-write.
- BRAM_ARB_LOCK_EN undefined: req_lock is ignored, and the lock state and its logic are removed.

## Test plan
- Reset, then requester 0 writes addr 3, data 0xA5, be all ones; requester 0 reads addr 3 the next cycle. Expect bram_wr_en = 1 in cycle 2, then rsp_valid = 1 for requester 0 with rsp_data = 0xA5 two cycles after the read is accepted.
- NUM_REQ = 3, all requesters issue reads every cycle. Expect grants in order 0, 1, 2, 0, 1, 2 and each rsp_valid tag matching the grant from two cycles earlier.
- NUM_COL = 2, DATA_WIDTH = 16: write 0xFFFF to addr 5, then write 0x1234 with be = 2'b01, then read addr 5. Expect 0xFF34.
- Write with be = 0 to addr 7 (previously 0x11), then read addr 7. Expect bram_wr_en to stay 0 and the read to return 0x11.
- Assert reset in the cycle after a read is accepted. Expect no rsp_valid, and requester 0 granted first after reset.
- BRAM_ARB_LOCK_EN defined: requester 1 reads with lock, goes idle for 2 cycles, then writes with lock = 0 while requester 0 holds req_valid throughout. Expect req_ready[0] = 0 until requester 1's write is accepted, then requester 0 granted next.
